// File: rtl/mmio_decoder.sv
// Memory-mapped I/O decoder: word-addressed data memory, debounced push buttons,
// synchronised switches and a multiplexed seven-segment hex display.
module mmio_decoder #(
   parameter int DMEM_WORDS      = 32,
   parameter int NUM_DIGITS      = 8,
   parameter int SW_WIDTH        = 16,
   parameter int NUM_BTN         = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SCAN_DIV        = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write,
   input  logic [7:0]            addr,
   input  logic [31:0]           writeData,
   output logic [31:0]           readData,
   input  logic [NUM_BTN-1:0]    btn,
   input  logic [SW_WIDTH-1:0]   switch,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            a2g,
   output logic                  dp
);

   localparam int DMEM_AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
   localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [5:0] WA_BTN  = 6'h20;
   localparam logic [5:0] WA_SW   = 6'h21;
   localparam logic [5:0] WA_DATA = 6'h22;
   localparam logic [5:0] WA_CTRL = 6'h23;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // ---------------------------------------------------------------- decode
   logic               is_dmem;
   logic [4:0]         dmem_idx;
   logic [DMEM_AW-1:0] dmem_word;
   logic               dmem_hit;
   logic               sel_btn;
   logic               sel_data;
   logic               sel_ctrl;
   logic               unused_addr_bits;

   assign is_dmem          = ~addr[7];
   assign dmem_idx         = addr[6:2];
   assign dmem_word        = dmem_idx[DMEM_AW-1:0];
   assign dmem_hit         = is_dmem && ({1'b0, dmem_idx} < 6'(DMEM_WORDS));
   assign sel_btn          = (addr[7:2] == WA_BTN);
   assign sel_data         = (addr[7:2] == WA_DATA);
   assign sel_ctrl         = (addr[7:2] == WA_CTRL);
   assign unused_addr_bits = ^addr[1:0];

   // ---------------------------------------------------------------- data memory
   // Not reset: contents must survive a reset pulse. Reads are combinational.
   logic [31:0] dmem [DMEM_WORDS];

   always_ff @(posedge clk) begin
      if (write && dmem_hit) begin
         dmem[dmem_word] <= writeData;
      end
   end

   // ---------------------------------------------------------------- buttons
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_flag;
   logic               btn_clr;

   assign btn_clr = write && sel_btn;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         logic             meta_reg;
         logic             sync_reg;
         logic             level_reg;
         logic             flag_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             accept;
         logic             rise;

         assign accept = (sync_reg != level_reg) && (cnt_reg == CNT_LAST);
         assign rise   = accept && sync_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               meta_reg  <= 1'b0;
               sync_reg  <= 1'b0;
               level_reg <= 1'b0;
               flag_reg  <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               meta_reg <= btn[gi];
               sync_reg <= meta_reg;
               if (sync_reg == level_reg) begin
                  cnt_reg <= '0;
               end else if (accept) begin
                  level_reg <= sync_reg;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
               // A fresh press beats a simultaneous write-1-to-clear.
               if (rise) begin
                  flag_reg <= 1'b1;
               end else if (btn_clr && writeData[gi]) begin
                  flag_reg <= 1'b0;
               end
            end
         end

         assign btn_level[gi] = level_reg;
         assign btn_flag[gi]  = flag_reg;
      end
   endgenerate

   // ---------------------------------------------------------------- switches
   logic [SW_WIDTH-1:0] sw_meta_reg;
   logic [SW_WIDTH-1:0] sw_sync_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_meta_reg <= '0;
         sw_sync_reg <= '0;
      end else begin
         sw_meta_reg <= switch;
         sw_sync_reg <= sw_meta_reg;
      end
   end

   // ---------------------------------------------------------------- display registers
   logic [31:0]           disp_data_reg;
   logic [NUM_DIGITS-1:0] disp_en_reg;
   logic [NUM_DIGITS-1:0] disp_dpm_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_data_reg <= '0;
         disp_en_reg   <= '1;
         disp_dpm_reg  <= '0;
      end else begin
         if (write && sel_data) begin
            disp_data_reg <= writeData;
         end
         if (write && sel_ctrl) begin
            disp_en_reg  <= writeData[NUM_DIGITS-1:0];
            disp_dpm_reg <= writeData[8 +: NUM_DIGITS];
         end
      end
   end

   // ---------------------------------------------------------------- read mux
   always_comb begin
      readData = '0;
      if (is_dmem) begin
         if (dmem_hit) begin
            readData = dmem[dmem_word];
         end
      end else begin
         case (addr[7:2])
            WA_BTN: begin
               readData[NUM_BTN-1:0]  = btn_flag;
               readData[16 +: NUM_BTN] = btn_level;
            end
            WA_SW:   readData[SW_WIDTH-1:0] = sw_sync_reg;
            WA_DATA: readData = disp_data_reg;
            WA_CTRL: begin
               readData[NUM_DIGITS-1:0]  = disp_en_reg;
               readData[8 +: NUM_DIGITS] = disp_dpm_reg;
            end
            default: readData = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------- scan and outputs
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h01;
         4'h1: s = 7'h4F;
         4'h2: s = 7'h12;
         4'h3: s = 7'h06;
         4'h4: s = 7'h4C;
         4'h5: s = 7'h24;
         4'h6: s = 7'h20;
         4'h7: s = 7'h0F;
         4'h8: s = 7'h00;
         4'h9: s = 7'h04;
         4'hA: s = 7'h08;
         4'hB: s = 7'h60;
         4'hC: s = 7'h31;
         4'hD: s = 7'h42;
         4'hE: s = 7'h30;
         default: s = 7'h38;
      endcase
      return s;
   endfunction

   logic [PRE_W-1:0]      presc_reg;
   logic [PRE_W-1:0]      presc_next;
   logic [IDX_W-1:0]      idx_reg;
   logic [IDX_W-1:0]      idx_next;
   logic [4:0]            nib_base;
   logic [3:0]            nibble;
   logic [NUM_DIGITS-1:0] an_reg;
   logic [NUM_DIGITS-1:0] an_next;
   logic [6:0]            a2g_reg;
   logic [6:0]            a2g_next;
   logic                  dp_reg;
   logic                  dp_next;

   always_comb begin
      presc_next = presc_reg + 1'b1;
      idx_next   = idx_reg;
      if (presc_reg == PRE_LAST) begin
         presc_next = '0;
         idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
   end

   // Output registers follow the current slot and register contents every cycle.
   always_comb begin
      nib_base = 5'({idx_reg, 2'b00});
      nibble   = disp_data_reg[nib_base +: 4];
      an_next  = '1;
      a2g_next = 7'h7F;
      dp_next  = 1'b1;
      if (disp_en_reg[idx_reg]) begin
         an_next[idx_reg] = 1'b0;
         a2g_next         = hex_to_seg(nibble);
         dp_next          = ~disp_dpm_reg[idx_reg];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_reg <= '0;
         idx_reg   <= '0;
         an_reg    <= '1;
         a2g_reg   <= 7'h7F;
         dp_reg    <= 1'b1;
      end else begin
         presc_reg <= presc_next;
         idx_reg   <= idx_next;
         an_reg    <= an_next;
         a2g_reg   <= a2g_next;
         dp_reg    <= dp_next;
      end
   end

   assign an  = an_reg;
   assign a2g = a2g_reg;
   assign dp  = dp_reg;

endmodule

// File: tb/tb_mmio_decoder.sv
// Self-checking bench for mmio_decoder: register/memory vector table, button and
// scan corner sequences, and randomized traffic against a behavioural model.
module tb_mmio_decoder;

   localparam int DW = 16;
   localparam int ND = 8;
   localparam int SW = 16;
   localparam int NB = 2;
   localparam int DB = 4;
   localparam int SD = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          write;
   logic [7:0]    addr;
   logic [31:0]   writeData;
   logic [31:0]   readData;
   logic [NB-1:0] btn;
   logic [SW-1:0] switch;
   logic [ND-1:0] an;
   logic [6:0]    a2g;
   logic          dp;

   mmio_decoder #(
      .DMEM_WORDS(DW), .NUM_DIGITS(ND), .SW_WIDTH(SW), .NUM_BTN(NB),
      .DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)
   ) dut (
      .clk(clk), .reset(reset), .write(write), .addr(addr), .writeData(writeData),
      .readData(readData), .btn(btn), .switch(switch), .an(an), .a2g(a2g), .dp(dp)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int edge_cnt;

   // Clock edges since reset release: the displayed slot is a pure function of time.
   always @(posedge clk or negedge reset) begin
      if (!reset) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Lit segments per hex value, by letter.
   string seg_table [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                             "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   function automatic logic [6:0] seg_exp(input int v);
      string      on;
      logic [6:0] s;
      int         j;
      s  = 7'h7F;
      on = seg_table[v];
      for (int i = 0; i < on.len(); i++) begin
         j    = 6 - (int'(on[i]) - 97);
         s[j] = 1'b0;
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      write = 1'b1; addr = a; writeData = d;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(name, readData, exp);
   endtask

   task automatic scan_check(input string name, input logic [31:0] data, input logic [31:0] ctrl,
                             input int ncyc);
      int         d;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         d = ((edge_cnt - 1) / SD) % ND;
         if (ctrl[d]) begin
            e_an  = ~(8'd1 << d);
            e_seg = seg_exp(int'(data[4*d +: 4]));
            e_dp  = ~ctrl[8+d];
         end else begin
            e_an  = 8'hFF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
         end
         check({name, "_an"}, 32'(an), 32'(e_an));
         check({name, "_a2g"}, 32'(a2g), 32'(e_seg));
         check({name, "_dp"}, 32'(dp), 32'(e_dp));
      end
      $display("scan %s data=%h ctrl=%h cycles=%0d", name, data, ctrl, ncyc);
   endtask

   typedef struct {
      bit          do_wr;
      logic [7:0]  a;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [13];
   logic [31:0] mdl [DW];
   bit          vld [DW];
   int          lat;
   bit          found;
   logic [31:0] rd, rc, sv;
   logic [7:0]  ra;
   int          ridx;

   initial begin
      tbl[0]  = '{1, 8'h04, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[1]  = '{1, 8'h3C, 32'hCAFEF00D, 32'hCAFEF00D};
      tbl[2]  = '{1, 8'h7C, 32'h12345678, 32'h00000000};
      tbl[3]  = '{0, 8'h3C, 32'h0,        32'hCAFEF00D};
      tbl[4]  = '{1, 8'h44, 32'h11111111, 32'h00000000};
      tbl[5]  = '{0, 8'h05, 32'h0,        32'hDEADBEEF};
      tbl[6]  = '{1, 8'h84, 32'hFFFFFFFF, 32'h00000000};
      tbl[7]  = '{1, 8'h90, 32'hFFFFFFFF, 32'h00000000};
      tbl[8]  = '{1, 8'hFC, 32'hA5A5A5A5, 32'h00000000};
      tbl[9]  = '{1, 8'h88, 32'h12345678, 32'h12345678};
      tbl[10] = '{1, 8'h8C, 32'hFFFFFFFF, 32'h0000FFFF};
      tbl[11] = '{1, 8'h8C, 32'h00000201, 32'h00000201};
      tbl[12] = '{1, 8'h80, 32'hFFFFFFFF, 32'h00000000};

      reset = 1'b0; write = 1'b0; addr = 8'h00; writeData = '0; btn = '0; switch = '0;
      repeat (3) @(negedge clk);
      check("rst_an", 32'(an), 32'hFF);
      check("rst_a2g", 32'(a2g), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      read_check("rst_data", 8'h88, 32'h0);
      read_check("rst_ctrl", 8'h8C, 32'hFF);
      read_check("rst_btn", 8'h80, 32'h0);
      read_check("rst_sw", 8'h84, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         if (tbl[i].do_wr) bus_write(tbl[i].a, tbl[i].wd);
         read_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].exp);
         $display("vec %0d wr=%0d addr=%h wd=%h rd=%h", i, tbl[i].do_wr, tbl[i].a, tbl[i].wd, readData);
         @(negedge clk);
      end

      // DISP_DATA=0x12345678, DISP_CTRL=0x201: only digit 0 lit, showing '8'.
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (edge_cnt > 0 && ((edge_cnt - 1) / SD) % ND == 0) begin
            check("dig0_an", 32'(an), 32'hFE);
            check("dig0_a2g", 32'(a2g), 32'h00);
            check("dig0_dp", 32'(dp), 32'h1);
            found = 1;
         end
      end
      if (!found) check("dig0_timeout", 32'h0, 32'h1);
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (edge_cnt > 0 && ((edge_cnt - 1) / SD) % ND == 1) begin
            check("dig1_an", 32'(an), 32'hFF);
            check("dig1_a2g", 32'(a2g), 32'h7F);
            check("dig1_dp", 32'(dp), 32'h1);
            found = 1;
         end
      end
      if (!found) check("dig1_timeout", 32'h0, 32'h1);
      scan_check("scan_fixed", 32'h12345678, 32'h201, 18);

      // Short glitch must not be accepted.
      addr = 8'h80;
      btn[0] = 1'b1;
      repeat (3) @(negedge clk);
      btn[0] = 1'b0;
      repeat (10) @(negedge clk);
      read_check("short_press", 8'h80, 32'h0);
      $display("btn short press status=%h", readData);

      // Held press: accepted within 6 cycles; measure the latency for later.
      btn[0] = 1'b1;
      lat = 0;
      for (int c = 1; c <= 6 && lat == 0; c++) begin
         @(negedge clk);
         addr = 8'h80;
         #1;
         if (readData == 32'h00010001) lat = c;
      end
      check("press_status", readData, 32'h00010001);
      $display("btn press status=%h latency=%0d", readData, lat);
      if (lat == 0) lat = 6;
      repeat (8 - lat) @(negedge clk);
      btn[0] = 1'b0;
      repeat (10) @(negedge clk);
      read_check("release_sticky", 8'h80, 32'h00000001);
      bus_write(8'h80, 32'h1);
      read_check("w1c_clear", 8'h80, 32'h0);
      $display("btn w1c status=%h", readData);

      // Clear of flag 1 lands on the same edge as its rising debounce.
      btn[1] = 1'b1;
      repeat (lat - 1) @(negedge clk);
      bus_write(8'h80, 32'h2);
      read_check("set_wins", 8'h80, 32'h00020002);
      $display("btn set-vs-clear status=%h", readData);
      btn[1] = 1'b0;
      repeat (10) @(negedge clk);
      bus_write(8'h80, 32'h3);
      read_check("clear_all", 8'h80, 32'h0);

      // Switch synchroniser latency.
      switch = 16'hA5A5;
      repeat (2) @(negedge clk);
      read_check("switch_sync", 8'h84, 32'h0000A5A5);
      $display("switch rd=%h", readData);

      // Reset mid-scan.
      bus_write(8'h8C, 32'hFF);
      bus_write(8'h88, 32'h89ABCDEF);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_mid_an", 32'(an), 32'hFF);
      check("rst_mid_a2g", 32'(a2g), 32'h7F);
      check("rst_mid_dp", 32'(dp), 32'h1);
      read_check("rst_mid_data", 8'h88, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idx_restart", 32'(an), 32'hFE);
      check("idx_restart_a2g", 32'(a2g), 32'(seg_exp(0)));
      read_check("dmem_persist", 8'h04, 32'hDEADBEEF);
      $display("reset pulse an=%h", an);
      scan_check("scan_after_rst", 32'h0, 32'hFF, 4);

      // Randomized display contents.
      for (int r = 0; r < 4; r++) begin
         rd = $urandom;
         rc = $urandom;
         bus_write(8'h88, rd);
         bus_write(8'h8C, rc);
         read_check("ctrl_rb", 8'h8C, rc & 32'h0000FFFF);
         repeat (2) @(negedge clk);
         scan_check($sformatf("scan_rand%0d", r), rd, rc, 18);
      end

      // Randomized switch values.
      for (int r = 0; r < 5; r++) begin
         sv = 32'($urandom_range(0, 65535));
         switch = sv[15:0];
         repeat (2) @(negedge clk);
         read_check("switch_rand", 8'h84, sv);
         $display("switch rand rd=%h", readData);
      end

      // Randomized memory traffic against an array model.
      for (int i = 0; i < DW; i++) vld[i] = 0;
      for (int r = 0; r < 150; r++) begin
         ra   = 8'($urandom_range(0, 127));
         ridx = int'(ra) / 4;
         if ($urandom_range(0, 1) == 1) begin
            rd = $urandom;
            bus_write(ra, rd);
            if (ridx < DW) begin
               mdl[ridx] = rd;
               vld[ridx] = 1;
            end
            $display("txn %0d wr addr=%h data=%h", r, ra, rd);
         end else begin
            if (ridx >= DW) begin
               read_check("dmem_oob", ra, 32'h0);
            end else if (vld[ridx]) begin
               read_check("dmem_rand", ra, mdl[ridx]);
            end else begin
               addr = ra;
               #1;
            end
            $display("txn %0d rd addr=%h data=%h", r, ra, readData);
            @(negedge clk);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
